fetch_pc_stack: RTL and testbench
=================================

Name: fetch_pc_stack

Overview:
- Instruction-fetch stage directly upstream of the 14-bit program ROM (11-bit address, 2K words).
- Holds the program counter, drives the ROM address, latches the returned word into an instruction register, and keeps an 8-level hardware return stack for CALL/RETURN.
- Redirect and skip requests come from the downstream decoder and refer to the instruction currently in the IR.
- Fetch is single-cycle: the ROM is combinational, so IR is valid one clock after PC presents the address.

Parameters:
- PC_W, 11, program counter / ROM address width.
- INSTR_W, 14, instruction width.
- STK_DEPTH, 8, return stack entries (power of two).
- NOP_WORD, 14'h0000, word inserted into IR on flush.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- en  input  1  advance enable; 0 = stall, all state holds
- Rom_addr_out  output  PC_W  ROM address, equals PC register
- Rom_data_in  input  INSTR_W  ROM word for Rom_addr_out
- Ir_out  output  INSTR_W  instruction register
- Ir_pc_out  output  PC_W  address the IR word was fetched from
- Ir_valid  output  1  1 = IR holds a real instruction, 0 = flushed bubble
- Jump_in  input  1  GOTO: redirect PC to Jump_addr_in
- Call_in  input  1  CALL: push return address, redirect to Jump_addr_in
- Ret_in  input  1  RETURN/RETLW: pop stack into PC
- Skip_in  input  1  skip-next: squash the instruction being fetched
- Jump_addr_in  input  PC_W  redirect target
- Stk_depth  output  4  live stack occupancy, 0..8
- Stk_ovf  output  1  sticky push-while-full flag
- Stk_unf  output  1  sticky pop-while-empty flag

Behaviour:
- Reset (async, rst_n=0): PC=0, Ir_out=NOP_WORD, Ir_pc_out=0, Ir_valid=0, stack pointer=0, Stk_depth=0, Stk_ovf=0, Stk_unf=0, all stack entries 0. Release is asserted asynchronously and takes effect at the next edge. Reset mid-redirect discards the redirect.
- Rom_addr_out is combinational from the PC register, with no extra latency.
- en=0: PC, IR, Ir_pc_out, Ir_valid, stack and flags all hold. Jump_in, Call_in, Ret_in and Skip_in are ignored, not queued.
- en=1, no request: IR<=Rom_data_in, Ir_pc_out<=PC, Ir_valid<=1, PC<=PC+1 modulo 2^PC_W (0x7FF wraps to 0x000).
- Request priority when several are asserted: Ret_in > Call_in > Jump_in > Skip_in. Only the winner acts.
- Ret_in: PC<=stack[sp-1], sp<=sp-1, IR<=NOP_WORD, Ir_valid<=0, Ir_pc_out<=PC.
- Call_in: stack[sp]<=PC (PC already equals CALL address+1), sp<=sp+1, PC<=Jump_addr_in, IR<=NOP_WORD, Ir_valid<=0.
- Jump_in: PC<=Jump_addr_in, IR<=NOP_WORD, Ir_valid<=0. The stack is unchanged.
- Skip_in: PC<=PC+1, IR<=NOP_WORD, Ir_valid<=0, Ir_pc_out<=PC. The word at PC is discarded.
- Every redirect or skip costs exactly one bubble cycle. The target word appears in IR on the following enabled edge.
- Stack is circular, with a 3-bit pointer that wraps:
  - Push at depth 8 overwrites the oldest entry. Depth stays 8 and Stk_ovf<=1.
  - Pop at depth 0 returns stack[sp-1] (stale or zero data) with sp wrapping. Depth stays 0 and Stk_unf<=1.
- Stk_ovf and Stk_unf are cleared only by reset.
- Downstream must ignore requests while Ir_valid=0. The block itself does not gate requests on Ir_valid.

Test Plan:
- Program image 0x0:01A5, 0x1:0103, 0x2:3007, 0x3:07A5, 0x4:0725, 0x5:2805. Release reset with en=1. Required: IR sequence 01A5/0103/3007/07A5/0725/2805, Ir_pc_out 0..5, Ir_valid=1 from the first edge, Rom_addr_out 0..6.
- When IR=2805 at pc 5, assert Jump_in with target 5 for one cycle. Required: next cycle Ir_valid=0, IR=0000, PC=5; the cycle after, IR=2805 with Ir_pc_out=5. The pattern repeats indefinitely.
- CALL at pc 0x010 targeting 0x100, then Ret_in at 0x105. Required: stack holds 0x011 and depth goes 1 then 0. After the Ret bubble, IR comes from 0x011.
- 9 consecutive Calls followed by 9 Rets. Required: depth saturates at 8 and Stk_ovf=1. The first 8 pops return in LIFO order and the ninth pop sets Stk_unf=1. Both flags persist until rst_n=0.
- Assert Jump_in and Ret_in together, and separately Skip_in with en=0. Required: Ret wins and the jump is ignored; with en=0 nothing changes, including PC.
- Assert rst_n=0 mid-cycle while depth=3 and PC=0x2A0. Required: outputs go immediately to their reset values, with depth=0 and PC=0.

Source files
------------

// File: rtl/fetch_pc_stack.sv
// Instruction-fetch stage: PC register, ROM address, instruction register and
// a circular hardware return stack for CALL/RETURN.
module fetch_pc_stack #(
  parameter int unsigned          PC_W      = 11,
  parameter int unsigned          INSTR_W   = 14,
  parameter int unsigned          STK_DEPTH = 8,
  parameter logic [INSTR_W-1:0]   NOP_WORD  = '0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  output logic [PC_W-1:0]         Rom_addr_out,
  input  logic [INSTR_W-1:0]      Rom_data_in,
  output logic [INSTR_W-1:0]      Ir_out,
  output logic [PC_W-1:0]         Ir_pc_out,
  output logic                    Ir_valid,
  input  logic                    Jump_in,
  input  logic                    Call_in,
  input  logic                    Ret_in,
  input  logic                    Skip_in,
  input  logic [PC_W-1:0]         Jump_addr_in,
  output logic [$clog2(STK_DEPTH):0] Stk_depth,
  output logic                    Stk_ovf,
  output logic                    Stk_unf
);

  localparam int unsigned SP_W  = $clog2(STK_DEPTH);
  localparam int unsigned DEP_W = SP_W + 1;
  localparam logic [DEP_W-1:0] DEPTH_FULL = DEP_W'(STK_DEPTH);

  logic [PC_W-1:0]    r_pc;
  logic [INSTR_W-1:0] r_ir;
  logic [PC_W-1:0]    r_ir_pc;
  logic               r_valid;
  logic [SP_W-1:0]    r_sp;
  logic [DEP_W-1:0]   r_depth;
  logic               r_ovf;
  logic               r_unf;
  logic [PC_W-1:0]    r_stack [STK_DEPTH];

  logic [PC_W-1:0]    w_pc_next;
  logic [SP_W-1:0]    w_sp_dec;
  logic               w_push;
  logic               w_pop;
  logic               w_bubble;

  // Next PC selection with priority Ret > Call > Jump > Skip > sequential.
  always_comb begin
    w_sp_dec  = r_sp - SP_W'(1);
    w_pop     = Ret_in;
    w_push    = Call_in & ~Ret_in;
    w_bubble  = Ret_in | Call_in | Jump_in | Skip_in;
    w_pc_next = r_pc + PC_W'(1);
    if (Ret_in) begin
      w_pc_next = r_stack[w_sp_dec];
    end else if (Call_in || Jump_in) begin
      w_pc_next = Jump_addr_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc    <= '0;
      r_ir    <= NOP_WORD;
      r_ir_pc <= '0;
      r_valid <= 1'b0;
      r_sp    <= '0;
      r_depth <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
      r_stack <= '{default: '0};
    end else if (en) begin
      r_pc    <= w_pc_next;
      r_ir_pc <= r_pc;
      if (w_bubble) begin
        r_ir    <= NOP_WORD;
        r_valid <= 1'b0;
      end else begin
        r_ir    <= Rom_data_in;
        r_valid <= 1'b1;
      end
      // Pointer always wraps; occupancy saturates and raises a sticky flag instead.
      if (w_pop) begin
        r_sp <= w_sp_dec;
        if (r_depth == '0) begin
          r_unf <= 1'b1;
        end else begin
          r_depth <= r_depth - DEP_W'(1);
        end
      end else if (w_push) begin
        r_stack[r_sp] <= r_pc;
        r_sp          <= r_sp + SP_W'(1);
        if (r_depth == DEPTH_FULL) begin
          r_ovf <= 1'b1;
        end else begin
          r_depth <= r_depth + DEP_W'(1);
        end
      end
    end
  end

  assign Rom_addr_out = r_pc;
  assign Ir_out       = r_ir;
  assign Ir_pc_out    = r_ir_pc;
  assign Ir_valid     = r_valid;
  assign Stk_depth    = r_depth;
  assign Stk_ovf      = r_ovf;
  assign Stk_unf      = r_unf;

endmodule

// File: tb/tb_fetch_pc_stack.sv
// Scoreboard bench for fetch_pc_stack: a reference fetch/stack model pushes the
// expected post-edge state, which is popped and compared after each edge.
module tb_fetch_pc_stack;

  localparam logic [13:0] NOP = 14'h0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [10:0] Rom_addr_out;
  logic [13:0] Rom_data_in;
  logic [13:0] Ir_out;
  logic [10:0] Ir_pc_out;
  logic        Ir_valid;
  logic        Jump_in, Call_in, Ret_in, Skip_in;
  logic [10:0] Jump_addr_in;
  logic [3:0]  Stk_depth;
  logic        Stk_ovf, Stk_unf;

  logic [13:0] rom [2048];

  fetch_pc_stack dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .Rom_addr_out(Rom_addr_out), .Rom_data_in(Rom_data_in),
    .Ir_out(Ir_out), .Ir_pc_out(Ir_pc_out), .Ir_valid(Ir_valid),
    .Jump_in(Jump_in), .Call_in(Call_in), .Ret_in(Ret_in), .Skip_in(Skip_in),
    .Jump_addr_in(Jump_addr_in),
    .Stk_depth(Stk_depth), .Stk_ovf(Stk_ovf), .Stk_unf(Stk_unf)
  );

  always #5 clk = ~clk;
  assign Rom_data_in = rom[Rom_addr_out];

  typedef struct {
    logic [13:0] ir;
    logic        v;
    logic [10:0] pcout;
    logic        pcok;
    logic [10:0] pc;
    logic [3:0]  depth;
    logic        ovf;
    logic        unf;
  } exp_t;

  exp_t sb[$];
  int n_chk = 0;
  int n_err = 0;

  // Reference model state
  logic [10:0] m_pc, m_pcout, m_stack [8];
  logic [13:0] m_ir;
  logic        m_v, m_pcok, m_ovf, m_unf;
  logic [2:0]  m_sp;
  logic [3:0]  m_depth;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = '0; m_pcout = '0; m_ir = NOP; m_v = 1'b0; m_pcok = 1'b1;
    m_ovf = 1'b0; m_unf = 1'b0; m_sp = '0; m_depth = '0;
    for (int i = 0; i < 8; i++) m_stack[i] = '0;
  endtask

  task automatic idle_inputs();
    en = 1'b0; Jump_in = 1'b0; Call_in = 1'b0; Ret_in = 1'b0; Skip_in = 1'b0;
    Jump_addr_in = '0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, ".addr"},  32'(Rom_addr_out), 32'h0);
    chk({tag, ".ir"},    32'(Ir_out),       32'(NOP));
    chk({tag, ".irpc"},  32'(Ir_pc_out),    32'h0);
    chk({tag, ".valid"}, 32'(Ir_valid),     32'h0);
    chk({tag, ".depth"}, 32'(Stk_depth),    32'h0);
    chk({tag, ".ovf"},   32'(Stk_ovf),      32'h0);
    chk({tag, ".unf"},   32'(Stk_unf),      32'h0);
  endtask

  // Drive one cycle of stimulus, predict, then compare after the edge.
  task automatic step(input logic e, input logic j, input logic c, input logic r,
                      input logic s, input logic [10:0] a);
    exp_t x;
    logic [2:0] idx;
    @(negedge clk);
    en = e; Jump_in = j; Call_in = c; Ret_in = r; Skip_in = s; Jump_addr_in = a;
    if (e) begin
      m_pcout = m_pc;
      if (r) begin
        idx = m_sp - 3'd1;
        m_sp = idx;
        if (m_depth == 4'd0) m_unf = 1'b1; else m_depth = m_depth - 4'd1;
        m_pc = m_stack[idx];
        m_ir = NOP; m_v = 1'b0; m_pcok = 1'b1;
      end else if (c) begin
        m_stack[m_sp] = m_pc;
        m_sp = m_sp + 3'd1;
        if (m_depth == 4'd8) m_ovf = 1'b1; else m_depth = m_depth + 4'd1;
        m_pc = a;
        m_ir = NOP; m_v = 1'b0; m_pcok = 1'b0;
      end else if (j) begin
        m_pc = a;
        m_ir = NOP; m_v = 1'b0; m_pcok = 1'b0;
      end else if (s) begin
        m_pc = m_pc + 11'd1;
        m_ir = NOP; m_v = 1'b0; m_pcok = 1'b1;
      end else begin
        m_ir = rom[m_pc]; m_v = 1'b1; m_pcok = 1'b1;
        m_pc = m_pc + 11'd1;
      end
    end
    x = '{ir: m_ir, v: m_v, pcout: m_pcout, pcok: m_pcok, pc: m_pc,
          depth: m_depth, ovf: m_ovf, unf: m_unf};
    sb.push_back(x);
    @(posedge clk);
    #1;
    x = sb.pop_front();
    chk("ir",    32'(Ir_out),       32'(x.ir));
    chk("valid", 32'(Ir_valid),     32'(x.v));
    if (x.pcok) chk("irpc", 32'(Ir_pc_out), 32'(x.pcout));
    chk("addr",  32'(Rom_addr_out), 32'(x.pc));
    chk("depth", 32'(Stk_depth),    32'(x.depth));
    chk("ovf",   32'(Stk_ovf),      32'(x.ovf));
    chk("unf",   32'(Stk_unf),      32'(x.unf));
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 11'h0);
  endtask

  logic [13:0] prog [6] = '{14'h01A5, 14'h0103, 14'h3007, 14'h07A5, 14'h0725, 14'h2805};

  initial begin
    for (int i = 0; i < 2048; i++) rom[i] = 14'(i * 37 + 11) ^ 14'h2A5A;
    for (int i = 0; i < 6; i++) rom[i] = prog[i];
    idle_inputs();
    model_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");

    // Straight-line fetch of the program image
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 11'h0);
      chk("seq.ir",   32'(Ir_out),       32'(prog[k]));
      chk("seq.irpc", 32'(Ir_pc_out),    32'(k));
      chk("seq.addr", 32'(Rom_addr_out), 32'(k + 1));
      chk("seq.v",    32'(Ir_valid),     32'h1);
    end

    // Jump-to-self loop at 5
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 11'h005);
      chk("loop.bubble", 32'(Ir_valid), 32'h0);
      chk("loop.pc",     32'(Rom_addr_out), 32'h5);
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 11'h0);
      chk("loop.ir",   32'(Ir_out),    32'h2805);
      chk("loop.irpc", 32'(Ir_pc_out), 32'h5);
    end

    // CALL at 0x010 -> 0x100, RETURN at 0x105
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 11'h010);
    run(1);
    chk("call.at", 32'(Ir_pc_out), 32'h010);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 11'h100);
    chk("call.depth", 32'(Stk_depth), 32'h1);
    run(6);
    chk("ret.at", 32'(Ir_pc_out), 32'h105);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 11'h0);
    chk("ret.pc",    32'(Rom_addr_out), 32'h011);
    chk("ret.depth", 32'(Stk_depth),    32'h0);
    run(1);
    chk("ret.irpc", 32'(Ir_pc_out), 32'h011);
    chk("ret.ir",   32'(Ir_out),    32'(rom[17]));

    // Nine calls then nine returns: overflow then underflow
    for (int k = 0; k < 9; k++) step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 11'(12'h200 + k));
    chk("ovf.depth", 32'(Stk_depth), 32'h8);
    chk("ovf.flag",  32'(Stk_ovf),   32'h1);
    for (int k = 0; k < 9; k++) begin
      step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 11'h0);
      if (k < 8) chk("lifo.pc", 32'(Rom_addr_out), 32'(12'h207 - k));
    end
    chk("unf.flag",  32'(Stk_unf),   32'h1);
    chk("unf.depth", 32'(Stk_depth), 32'h0);
    run(3);
    chk("sticky.ovf", 32'(Stk_ovf), 32'h1);
    chk("sticky.unf", 32'(Stk_unf), 32'h1);

    // Ret beats Jump; en=0 freezes everything
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 11'h300);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 11'h310);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 11'h320);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 11'h123);
    chk("prio.pc", 32'(Rom_addr_out), 32'h310);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 11'h290);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 11'h0);
    chk("stall.pc", 32'(Rom_addr_out), 32'h290);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 11'h055);
    chk("stall.depth", 32'(Stk_depth), 32'h3);
    run(7);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 11'h0);
    run(8);
    chk("pre.pc",    32'(Rom_addr_out), 32'h2A0);
    chk("pre.depth", 32'(Stk_depth),    32'h3);

    // Asynchronous reset in the middle of a cycle
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async");
    idle_inputs();
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    run(2);
    chk("post.ir", 32'(Ir_out), 32'h0103);

    // Random traffic against the model
    for (int k = 0; k < 300; k++) begin
      step(($urandom_range(0, 3) != 0), ($urandom_range(0, 5) == 0),
           ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0),
           ($urandom_range(0, 5) == 0), 11'($urandom_range(0, 2047)));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
